// File: rtl/mem_req_arbiter.sv
// mem_req_arbiter: merges icache and dcache line requests onto the single
// main-memory request port, tracks which cache owns each outstanding read in an
// in-order ID FIFO, and steers each memory response back to its cache.
// dcache has default priority; icache takes priority after STARVE_LIMIT
// consecutive losses.
module mem_req_arbiter #(
  parameter  int LINE_SIZE    = 4,
  parameter  int ACTIVE_REQS  = 4,
  parameter  int STARVE_LIMIT = 8,
  localparam int LINE_W       = LINE_SIZE * 32,
  localparam int CNT_W        = $clog2(ACTIVE_REQS + 1)
) (
  input  logic              clk,
  input  logic              rst,
  // icache request
  input  logic              ic_req_valid,
  input  logic [31:0]       ic_req_addr,
  output logic              ic_req_ready,
  // dcache request
  input  logic              dc_req_valid,
  input  logic [31:0]       dc_req_addr,
  input  logic [LINE_W-1:0] dc_req_data,
  input  logic              dc_req_store,
  input  logic              dc_req_wb,
  output logic              dc_req_ready,
  // main-memory request
  output logic              mem_req_valid,
  output logic [31:0]       mem_req_addr,
  output logic [LINE_W-1:0] mem_req_data,
  output logic              mem_req_store,
  output logic              mem_req_wb,
  input  logic              mem_req_ready,
  // main-memory response (in issue order, no backpressure)
  input  logic              mem_resp_valid,
  input  logic [31:0]       mem_resp_addr,
  input  logic [LINE_W-1:0] mem_resp_data,
  // responses back to the caches
  output logic              ic_resp_valid,
  output logic [31:0]       ic_resp_addr,
  output logic [LINE_W-1:0] ic_resp_data,
  output logic              dc_resp_valid,
  output logic [31:0]       dc_resp_addr,
  output logic [LINE_W-1:0] dc_resp_data,
  // status
  output logic [CNT_W-1:0]  outstanding,
  output logic              err
);

  localparam int               PTR_W    = (ACTIVE_REQS > 1) ? $clog2(ACTIVE_REQS) : 1;
  localparam logic [CNT_W-1:0] MAX_OUT  = CNT_W'(ACTIVE_REQS);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(ACTIVE_REQS - 1);
  localparam logic [7:0]       LIMIT    = 8'(STARVE_LIMIT);

  // Requester IDs stored in the FIFO.
  localparam logic ID_IC = 1'b0;
  localparam logic ID_DC = 1'b1;

  logic                   can_load;
  logic                   resp_pop;
  logic                   read_ok;
  logic                   ic_ok;
  logic                   dc_ok;
  logic                   ic_pri;
  logic                   ic_grant;
  logic                   dc_grant;
  logic                   push;
  logic                   head_id;
  logic [7:0]             starve_cnt;
  logic [PTR_W-1:0]       wr_ptr;
  logic [PTR_W-1:0]       rd_ptr;
  logic [ACTIVE_REQS-1:0] id_mem;

  // The output register can take a new request when empty or draining this cycle.
  assign can_load = !mem_req_valid || mem_req_ready;
  // A response only retires something when the FIFO holds an owner for it.
  assign resp_pop = mem_resp_valid && (outstanding != '0);
  // A read may issue below the limit, or at the limit when a slot frees this cycle.
  assign read_ok  = (outstanding < MAX_OUT) || resp_pop;
  assign ic_ok    = ic_req_valid && read_ok;
  // Writebacks never get a response, so they bypass the read limit.
  assign dc_ok    = dc_req_valid && (dc_req_wb || read_ok);
  assign ic_pri   = (starve_cnt == LIMIT);
  assign push     = ic_grant || (dc_grant && !dc_req_wb);
  assign head_id  = id_mem[rd_ptr];

  assign ic_req_ready = ic_grant;
  assign dc_req_ready = dc_grant;

  // Single-winner grant; an ineligible requester never blocks the other.
  always_comb begin
    // NOTE: every signal assigned here gets a default first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    ic_grant = 1'b0;
    dc_grant = 1'b0;
    if (can_load && !rst) begin
      if (ic_pri && ic_ok) ic_grant = 1'b1;
      else if (dc_ok)      dc_grant = 1'b1;
      else if (ic_ok)      ic_grant = 1'b1;
    end
  end

  // Output request register: load the winner, drop valid once memory takes it.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: state in clocked blocks uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (rst) begin
      mem_req_valid <= 1'b0;
      mem_req_addr  <= '0;
      mem_req_data  <= '0;
      mem_req_store <= 1'b0;
      mem_req_wb    <= 1'b0;
    end else if (ic_grant) begin
      mem_req_valid <= 1'b1;
      mem_req_addr  <= ic_req_addr;
      mem_req_data  <= '0;
      mem_req_store <= 1'b0;
      mem_req_wb    <= 1'b0;
    end else if (dc_grant) begin
      mem_req_valid <= 1'b1;
      mem_req_addr  <= dc_req_addr;
      mem_req_data  <= dc_req_data;
      mem_req_store <= dc_req_store;
      mem_req_wb    <= dc_req_wb;
    end else if (mem_req_ready) begin
      mem_req_valid <= 1'b0;
    end
  end

  // Starvation counter: counts icache losses to dcache, saturating at the limit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      starve_cnt <= '0;
    end else if (ic_grant) begin
      starve_cnt <= '0;
    end else if (ic_req_valid && dc_grant && (starve_cnt != LIMIT)) begin
      starve_cnt <= starve_cnt + 8'd1;
    end
  end

  // ID FIFO pointers and occupancy (occupancy is the outstanding read count).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      outstanding <= '0;
    end else begin
      if (push)     wr_ptr <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + PTR_W'(1);
      if (resp_pop) rd_ptr <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + PTR_W'(1);
      case ({push, resp_pop})
        2'b10:   outstanding <= outstanding + CNT_W'(1);
        2'b01:   outstanding <= outstanding - CNT_W'(1);
        default: outstanding <= outstanding;
      endcase
    end
  end

  // ID FIFO storage: written on each read grant.
  always_ff @(posedge clk) begin
    // NOTE: the storage array has no reset; an entry is only read after it has been
    // written, and the pointers/occupancy (which are reset) define which entries are live.
    if (push) id_mem[wr_ptr] <= dc_grant ? ID_DC : ID_IC;
  end

  // Response routing: one-cycle pulse to the owner at the FIFO head; sticky error on orphans.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ic_resp_valid <= 1'b0;
      ic_resp_addr  <= '0;
      ic_resp_data  <= '0;
      dc_resp_valid <= 1'b0;
      dc_resp_addr  <= '0;
      dc_resp_data  <= '0;
      err           <= 1'b0;
    end else begin
      ic_resp_valid <= resp_pop && (head_id == ID_IC);
      dc_resp_valid <= resp_pop && (head_id == ID_DC);
      if (resp_pop && (head_id == ID_IC)) begin
        ic_resp_addr <= mem_resp_addr;
        ic_resp_data <= mem_resp_data;
      end
      if (resp_pop && (head_id == ID_DC)) begin
        dc_resp_addr <= mem_resp_addr;
        dc_resp_data <= mem_resp_data;
      end
      if (mem_resp_valid && (outstanding == '0)) err <= 1'b1;
    end
  end

endmodule
